armleocpu_mul_frontend: RTL and testbench



---
 rtl/armleocpu_mul_frontend_pkg.sv | 15 +
 rtl/armleocpu_mul_frontend_signfix.sv | 32 +++
 rtl/armleocpu_multiplier.sv | 49 ++++
 rtl/armleocpu_mul_frontend.sv | 107 ++++++++++
 tb/tb_armleocpu_mul_frontend.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/armleocpu_mul_frontend_pkg.sv
// Shared opcodes and frontend state encoding for the RV32M multiply path.
package armleocpu_defines;

  localparam logic [1:0] MUL_OP_MUL    = 2'd0;
  localparam logic [1:0] MUL_OP_MULH   = 2'd1;
  localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
  localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_WAIT  = 2'd1,
    STATE_DRAIN = 2'd2
  } mul_fe_state_t;

endpackage

// File: rtl/armleocpu_mul_frontend_signfix.sv
// Operand magnitude conversion and product sign correction / half select.
module armleocpu_mul_signfix
  import armleocpu_defines::*;
(
  input  logic [1:0]  i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output logic [31:0] o_factor0,
  output logic [31:0] o_factor1,
  output logic        o_neg,
  input  logic [1:0]  i_res_op,
  input  logic        i_res_neg,
  input  logic [63:0] i_product,
  output logic [31:0] o_result
);

  logic        w_s1;
  logic        w_s2;
  logic [63:0] w_p;

  assign w_s1 = ((i_op == MUL_OP_MULH) || (i_op == MUL_OP_MULHSU)) ? i_rs1[31] : 1'b0;
  assign w_s2 = (i_op == MUL_OP_MULH) ? i_rs2[31] : 1'b0;

  // 0x80000000 negates to itself, which is still the correct unsigned magnitude
  assign o_factor0 = w_s1 ? (~i_rs1 + 32'd1) : i_rs1;
  assign o_factor1 = w_s2 ? (~i_rs2 + 32'd1) : i_rs2;
  assign o_neg     = w_s1 ^ w_s2;

  assign w_p      = i_res_neg ? (~i_product + 64'd1) : i_product;
  assign o_result = (i_res_op == MUL_OP_MUL) ? w_p[31:0] : w_p[63:32];

endmodule

// File: rtl/armleocpu_multiplier.sv
// Unsigned 32x32 multiplier with a valid/ready handshake and fixed latency.
module armleocpu_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  input  logic [31:0] factor0,
  input  logic [31:0] factor1,
  output logic        ready,
  output logic [63:0] result
);

  typedef enum logic [1:0] {M_IDLE, M_BUSY, M_DONE} mstate_t;

  mstate_t     r_state;
  logic [2:0]  r_cnt;
  logic        r_ready;
  logic [63:0] r_prod;

  // DONE spends one cycle ignoring valid so the requester can drop it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= M_IDLE;
      r_cnt   <= 3'd0;
      r_ready <= 1'b0;
      r_prod  <= 64'd0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        M_IDLE: if (valid) begin
          r_prod  <= {32'd0, factor0} * {32'd0, factor1};
          r_cnt   <= 3'd5;
          r_state <= M_BUSY;
        end
        M_BUSY: if (r_cnt == 3'd0) begin
          r_ready <= 1'b1;
          r_state <= M_DONE;
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
        M_DONE:  r_state <= M_IDLE;
        default: r_state <= M_IDLE;
      endcase
    end
  end

  assign ready  = r_ready;
  assign result = r_prod;

endmodule

// File: rtl/armleocpu_mul_frontend.sv
// RV32M multiply issue/retire stage between execute and the unsigned multiplier.
module armleocpu_mul_frontend
  import armleocpu_defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        kill,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        mul_valid,
  output logic [31:0] mul_factor0,
  output logic [31:0] mul_factor1,
  input  logic        mul_ready,
  input  logic [63:0] mul_result
);

  mul_fe_state_t r_state;
  mul_fe_state_t w_next_state;
  logic [1:0]    r_op;
  logic          r_neg;
  logic          r_mul_valid;
  logic [31:0]   r_factor0;
  logic [31:0]   r_factor1;
  logic          r_res_valid;
  logic [31:0]   r_res_data;
  logic [31:0]   w_factor0;
  logic [31:0]   w_factor1;
  logic          w_neg;
  logic [31:0]   w_result;

  armleocpu_mul_signfix u_signfix (
    .i_op      (req_op),
    .i_rs1     (req_rs1),
    .i_rs2     (req_rs2),
    .o_factor0 (w_factor0),
    .o_factor1 (w_factor1),
    .o_neg     (w_neg),
    .i_res_op  (r_op),
    .i_res_neg (r_neg),
    .i_product (mul_result),
    .o_result  (w_result)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= STATE_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      STATE_IDLE:  if (req_valid && !kill) w_next_state = STATE_WAIT;
      STATE_WAIT: begin
        if (mul_ready)  w_next_state = STATE_IDLE;
        else if (kill)  w_next_state = STATE_DRAIN;
      end
      STATE_DRAIN: if (mul_ready) w_next_state = STATE_IDLE;
      default:     w_next_state = STATE_IDLE;
    endcase
  end

  // mul_valid is held through DRAIN: the multiplier cannot be aborted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= MUL_OP_MUL;
      r_neg       <= 1'b0;
      r_mul_valid <= 1'b0;
      r_factor0   <= 32'd0;
      r_factor1   <= 32'd0;
      r_res_valid <= 1'b0;
      r_res_data  <= 32'd0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        STATE_IDLE: if (req_valid && !kill) begin
          r_op        <= req_op;
          r_neg       <= w_neg;
          r_factor0   <= w_factor0;
          r_factor1   <= w_factor1;
          r_mul_valid <= 1'b1;
        end
        STATE_WAIT: if (mul_ready) begin
          r_mul_valid <= 1'b0;
          if (!kill) begin
            r_res_valid <= 1'b1;
            r_res_data  <= w_result;
          end
        end
        STATE_DRAIN: if (mul_ready) r_mul_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign req_ready   = (r_state == STATE_IDLE);
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;
  assign mul_valid   = r_mul_valid;
  assign mul_factor0 = r_factor0;
  assign mul_factor1 = r_factor1;

endmodule

// File: tb/tb_armleocpu_mul_frontend.sv
// Directed bench for the multiply frontend driving the real multiplier.
module tb_armleocpu_mul_frontend;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_rs1 = 32'd0;
  logic [31:0] req_rs2 = 32'd0;
  logic        kill = 1'b0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        mul_valid;
  logic [31:0] mul_factor0;
  logic [31:0] mul_factor1;
  logic        mul_ready;
  logic [63:0] mul_result;
  logic        mul_rst_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;
  assign mul_rst_n = ~rst;

  armleocpu_mul_frontend dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .kill(kill),
    .res_valid(res_valid), .res_data(res_data),
    .mul_valid(mul_valid), .mul_factor0(mul_factor0), .mul_factor1(mul_factor1),
    .mul_ready(mul_ready), .mul_result(mul_result)
  );

  armleocpu_multiplier u_mul (
    .clk(clk), .rst_n(mul_rst_n), .valid(mul_valid),
    .factor0(mul_factor0), .factor1(mul_factor1),
    .ready(mul_ready), .result(mul_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge with the frontend in IDLE; returns one negedge later.
  task automatic start_req(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                           input string tag);
    chk({tag, "_rdy"}, req_ready, 1);
    req_op = op; req_rs1 = rs1; req_rs2 = rs2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_busy"}, req_ready, 0);
    chk({tag, "_mvld"}, mul_valid, 1);
  endtask

  // Returns at the negedge where res_valid is seen; lat counts edges after acceptance.
  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] f0, input logic [31:0] f1, input logic [31:0] exp,
                        input string tag);
    int lat;
    @(negedge clk);
    start_req(op, rs1, rs2, tag);
    chk({tag, "_f0"}, mul_factor0, f0);
    chk({tag, "_f1"}, mul_factor1, f1);
    wait_res(lat);
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_data"}, res_data, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, res_valid, 0);
    chk({tag, "_mvld_lo"}, mul_valid, 0);
    chk({tag, "_hold"}, res_data, exp);
  endtask

  initial begin
    int lat;
    int cnt;
    int pulses;
    int rpulses;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_rdy", req_ready, 1);
    chk("rst_rv", res_valid, 0);
    chk("rst_rd", res_data, 0);
    chk("rst_mv", mul_valid, 0);
    chk("rst_f0", mul_factor0, 0);
    chk("rst_f1", mul_factor1, 0);

    run_op(2'd0, 32'd7,        32'hFFFFFFFD, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run_op(2'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    run_op(2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run_op(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
    run_op(2'd1, 32'd0,        32'h80000000, 32'd0,        32'h80000000, 32'd0,        "mulh_zero");
    run_op(2'd1, 32'hFFFFFFFB, 32'd3,        32'd5,        32'd3,        32'hFFFFFFFF, "mulh_neg");

    // Kill two cycles after acceptance, plus a second kill while draining.
    @(negedge clk);
    start_req(2'd0, 32'd9, 32'd9, "kill");
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    pulses = 0;
    @(negedge clk);
    @(negedge clk); kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("drain_rdy", req_ready, 0);
    cnt = 0;
    while (!req_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (res_valid) pulses++;
    end
    chk("drain_wait", cnt, 3);
    chk("drain_nores", pulses, 0);
    chk("drain_mvld", mul_valid, 0);
    // Back-to-back request in the first IDLE cycle after the drain.
    start_req(2'd0, 32'd6, 32'd7, "b2b");
    wait_res(lat);
    chk("b2b_lat", lat, 8);
    chk("b2b_data", res_data, 32'd42);
    // Accept again in the cycle res_valid is high.
    start_req(2'd3, 32'h00010000, 32'h00030000, "onres");
    wait_res(lat);
    chk("onres_lat", lat, 8);
    chk("onres_data", res_data, 32'd3);
    rpulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (mul_ready) rpulses++;
    end
    chk("no_retrigger", rpulses, 0);

    // kill arriving together with mul_ready discards the result.
    @(negedge clk);
    start_req(2'd0, 32'd2, 32'd3, "kmr");
    cnt = 0;
    while (!mul_ready && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("kmr_readyseen", cnt, 7);
    kill = 1'b1;
    @(negedge clk); kill = 1'b0;
    chk("kmr_rv", res_valid, 0);
    chk("kmr_mv", mul_valid, 0);
    chk("kmr_rdy", req_ready, 1);
    chk("kmr_hold", res_data, 32'd3);

    // Reset while waiting on the multiplier.
    @(negedge clk);
    start_req(2'd1, 32'd100, 32'd100, "rstw");
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rstw_rdy", req_ready, 1);
    chk("rstw_rv", res_valid, 0);
    chk("rstw_rd", res_data, 0);
    chk("rstw_mv", mul_valid, 0);
    chk("rstw_f0", mul_factor0, 0);
    chk("rstw_f1", mul_factor1, 0);
    pulses = 0;
    rpulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) pulses++;
      if (mul_ready) rpulses++;
    end
    chk("rstw_nores", pulses, 0);
    chk("rstw_nomul", rpulses, 0);
    run_op(2'd0, 32'd11, 32'd13, 32'd11, 32'd13, 32'd143, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
